csa_resolve_seq: RTL and testbench
==================================

Name: csa_resolve_seq

Overview:
Sequential carry-save-to-binary resolver. It is the consumer end of the team's carry-save adder stages. It accepts a redundant (sum, carry) word pair, where carry bit i has weight 2^(i+1), and returns the true binary value s + 2*c. The addition runs as a multi-cycle chunked ripple with a registered inter-chunk carry. It sits after the final carry-save reduction level of the Wallace-tree multiplier and uses a valid/ready handshake on both sides.

Parameters:
WIDTH, 16, width of the s and c input vectors; must be a multiple of CHUNK.
CHUNK, 4, bits resolved per cycle; must be at least 2.
Derived (localparam): NCHUNK = WIDTH/CHUNK + 1 (5 at defaults); internal operand width NCHUNK*CHUNK (20 at defaults).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  s/c pair presented.
in_ready  output  1  resolver can accept; high only in IDLE.
in_s  input  WIDTH  carry-save sum vector.
in_c  input  WIDTH  carry-save carry vector; bit i has weight 2^(i+1).
out_valid  output  1  result available; high only in DONE.
out_ready  input  1  downstream accepts result.
out_sum  output  WIDTH+2  binary result in_s + 2*in_c.
busy  output  1  high in RUN or DONE.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state changes occur on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, chunk index=0, chunk carry=0.
- Operand forming at accept:
  - A = in_s zero-extended to NCHUNK*CHUNK bits.
  - B = {in_c,1'b0} zero-extended to NCHUNK*CHUNK bits.
  - Both are captured into internal registers; the inputs may change freely after accept.
- States:
  - IDLE: in_ready=1. If in_valid, then on the edge: capture A and B, index=0, carry=0, go to RUN. Otherwise stay in IDLE.
  - RUN: in_ready=0, busy=1. Each cycle, add chunk[index] of A, chunk[index] of B and the carry.
    - Write the CHUNK-bit result into chunk[index] of the result register.
    - Register the carry-out and increment index.
    - When index==NCHUNK-1, go to DONE on that edge; the final carry-out is discarded and is always 0 by construction.
  - DONE: out_valid=1, out_sum = low WIDTH+2 bits of the result register, held stable while out_ready=0.
    - If out_ready is high, go to IDLE on the edge; out_valid drops the next cycle.
    - out_sum keeps its last value in IDLE until the next result is written; it is only meaningful while out_valid=1.
- Latency: accept edge E. out_valid is high in the cycle after edge E+NCHUNK (5 compute edges at defaults). Minimum issue interval is NCHUNK+2 cycles.
- Non-overlap: in_ready is 0 in RUN and DONE. in_valid asserted in those states is ignored and no capture occurs. Same-cycle result drain and new accept is not supported.
- Range: the maximum result is (2^WIDTH-1)*3, which fits in WIDTH+2 bits. No overflow is possible and no flag is provided.
- Reset mid-operation, in RUN or DONE: the next edge returns to reset values and the pending result is dropped with no out_valid pulse.
- in_valid and rst high in the same cycle: reset wins and nothing is captured.
- Control state encoding is free, but no X may appear on outputs after reset.

Test Plan:
- in_s=0x000A, in_c=0x000A, out_ready=1 -> out_valid rises exactly 5 cycles after the accept edge, out_sum=30 (0x0001E), 1-cycle out_valid pulse.
- in_s=0xFFFF, in_c=0xFFFF -> out_sum=0x2FFFD (196605). Checks the carry crossing every chunk boundary and the top chunk.
- Feed the output of a 16-bit carry-save stage for x=10, y=10, z=12345 -> out_sum=12365. Repeat for random x, y, z and check against x+y+z.
- Hold out_ready=0 for 7 cycles in DONE with in_valid=1 and different in_s/in_c -> out_sum stable, in_ready=0, no capture. Release out_ready -> IDLE next cycle, then the new pair is accepted.
- Assert rst for 1 cycle at RUN index 2 -> next cycle in_ready=1, out_valid=0, busy=0, out_sum=0, no stale out_valid. A following transaction with in_s=1, in_c=1 returns 3.
- Back-to-back: keep in_valid=1 and out_ready=1 continuously -> accepts are spaced NCHUNK+2=7 cycles apart, every result is correct, none is dropped or duplicated.

Source files
------------

// File: rtl/csa_resolve_seq.sv
// csa_resolve_seq: resolves a carry-save (sum, carry) pair into binary s + 2*c
// using a multi-cycle chunked ripple with a registered inter-chunk carry.
module csa_resolve_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] out_sum,
    output logic             busy
);
    localparam int NCHUNK = WIDTH / CHUNK + 1;
    localparam int OW = NCHUNK * CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [OW-1:0]  r_a;
    logic [OW-1:0]  r_b;
    logic [OW-1:0]  r_res;
    logic [IW-1:0]  r_idx;
    logic           r_cy;
    logic [CHUNK:0] w_add;
    logic           w_last;
    logic           w_accept;
    logic           w_unused_res;

    assign w_add = {1'b0, r_a[r_idx*CHUNK +: CHUNK]} + {1'b0, r_b[r_idx*CHUNK +: CHUNK]} + (CHUNK+1)'(r_cy);
    assign w_last = r_idx == IW'(NCHUNK - 1);
    assign w_accept = (r_state == IDLE) && in_valid;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (in_valid ? RUN : IDLE)
               : (r_state == RUN)  ? (w_last ? DONE : RUN)
               : (out_ready ? IDLE : DONE);
    end

    // The final carry-out of the top chunk is always 0, so it is simply not kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_idx <= '0;
            r_cy  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= OW'(in_s);
            r_b   <= OW'({in_c, 1'b0});
            r_idx <= '0;
            r_cy  <= 1'b0;
        end else if (r_state == RUN) begin
            r_res[r_idx*CHUNK +: CHUNK] <= w_add[CHUNK-1:0];
            r_cy  <= w_add[CHUNK];
            r_idx <= r_idx + IW'(1);
        end
    end

    assign in_ready     = r_state == IDLE;
    assign out_valid    = r_state == DONE;
    assign busy         = r_state != IDLE;
    assign out_sum      = r_res[WIDTH+1:0];
    assign w_unused_res = ^r_res;
endmodule

// File: tb/tb_csa_resolve_seq.sv
// tb_csa_resolve_seq: scoreboard bench for csa_resolve_seq; the driver queues the
// arithmetic result of each accepted pair and a negedge monitor checks every output.
module tb_csa_resolve_seq;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCHUNK = WIDTH / CHUNK + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_s = '0;
    logic [WIDTH-1:0] in_c = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH+1:0] out_sum;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int exp_q[$];
    int lat_q[$];
    bit chk_space = 0;
    bit have_last = 0;
    int last_acc = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [WIDTH+1:0] ps = '0;

    csa_resolve_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_s(in_s), .in_c(in_c), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: sampled mid-cycle, inputs only change just after the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !pv) begin
                if (lat_q.size() == 0) check("unexpected_out_valid", out_valid, 0);
                else check("latency", cyc - lat_q.pop_front(), NCHUNK);
            end
            if (out_valid && pv && pr) check("out_valid_pulse", out_valid, 0);
            if (out_valid && pv && !pr) check("out_sum_stable", out_sum, ps);
            if (out_valid && out_ready && exp_q.size() != 0) check("out_sum", out_sum, exp_q.pop_front());
        end
        pv = out_valid;
        pr = out_ready;
        ps = out_sum;
    end

    task automatic send(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c, input int e, input bit keep);
        int n = 0;
        in_s = s;
        in_c = c;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 40) begin
                check("accept_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(e);
        lat_q.push_back(cyc + 1);
        if (chk_space && have_last) check("issue_spacing", cyc + 1 - last_acc, NCHUNK + 2);
        last_acc = cyc + 1;
        have_last = 1;
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || !in_ready) && n < 60);
        if (n >= 60) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_csa(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] z);
        send(x ^ y ^ z, (x & y) | (x & z) | (y & z), int'(x) + int'(y) + int'(z), 0);
        drain();
    endtask

    initial begin
        logic [WIDTH-1:0] s, c;
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_out_sum", out_sum, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        send(16'h000A, 16'h000A, 30, 0);
        drain();
        send(16'hFFFF, 16'hFFFF, 196605, 0);
        drain();
        send_csa(16'd10, 16'd10, 16'd12345);
        for (int i = 0; i < 15; i++)
            send_csa(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        for (int i = 0; i < 15; i++) begin
            s = 16'($urandom_range(0, 65535));
            c = 16'($urandom_range(0, 65535));
            send(s, c, int'(s) + 2 * int'(c), 0);
            drain();
        end

        // Result held in DONE while a new pair is offered and must be ignored.
        out_ready = 1'b0;
        send(16'h1234, 16'h0F0F, 'h1234 + 2 * 'h0F0F, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        check("hold_reach_done", out_valid, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_s = 16'hABCD;
        in_c = 16'h5555;
        repeat (7) begin
            @(negedge clk);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_idle", in_ready, 1);
        send(16'hABCD, 16'h5555, 'hABCD + 2 * 'h5555, 0);
        drain();

        // Reset while RUN is on chunk index 2: pending result must vanish.
        send(16'h1111, 16'h2222, 'h1111 + 2 * 'h2222, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_sum", out_sum, 0);
        repeat (8) @(posedge clk);
        #1;
        send(16'd1, 16'd1, 3, 0);
        drain();

        // Reset and in_valid together: nothing is captured.
        rst = 1'b1;
        in_valid = 1'b1;
        in_s = 16'h0005;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_vs_valid_busy", busy, 0);
        check("rst_vs_valid_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        chk_space = 1;
        have_last = 0;
        for (int i = 0; i < 8; i++) begin
            s = 16'($urandom_range(0, 65535));
            c = 16'($urandom_range(0, 65535));
            send(s, c, int'(s) + 2 * int'(c), 1);
        end
        in_valid = 1'b0;
        chk_space = 0;
        drain();
        repeat (10) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        check("latency_queue_empty", lat_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
